fg_sequencer: RTL and testbench
===============================

Name: fg_sequencer

Overview:
- Programmable step sequencer that configures and sequences the Function_Generator datapath.
- Holds a small program of waveform settings: func, frequency select, amplitude select and phase control, each with a dwell time.
- Applies the steps in order. On every step change it pulses the generator's active-low clear, so each new waveform starts phase-aligned.
- Sits between the control/register interface and the Function_Generator config inputs.

Parameters:
DEPTH, 8, number of program entries (power of 2)
ADDR_W, 3, log2(DEPTH)
DWELL_W, 8, width of per-entry dwell field
PRESCALE, 1000, clk cycles per dwell tick (>=2)
CLR_CYCLES, 2, cycles gen_clr_n is held low at each step change (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cfg_we  in  1  program-entry write strobe
cfg_addr  in  ADDR_W  entry index to write
cfg_wdata  in  10+DWELL_W  {dwell, phase, amp_sel[1:0], freq_sel[3:0], func[2:0]}, func in LSBs
start  in  1  level/pulse; begins sequence from entry 0 when idle
stop  in  1  abort sequence, return to IDLE
loop_en  in  1  restart at entry 0 after last_idx instead of finishing
last_idx  in  ADDR_W  index of final step; sampled at start
func  out  3  to generator func
freq_sel  out  4  to generator Freq_select[3:0]
amp_sel  out  2  to generator AMP_sel
phase_cntrl  out  1  to generator Phase_cntrl
gen_clr_n  out  1  to generator CLR (active-low)
busy  out  1  high in APPLY/DWELL
step_idx  out  ADDR_W  currently applied entry
seq_done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset (reset=0, asynchronous):
  - State=IDLE.
  - All program entries=0.
  - func, freq_sel, amp_sel, phase_cntrl, step_idx, busy and seq_done all =0.
  - gen_clr_n=0.
  - Prescaler and dwell counter =0.
- IDLE:
  - gen_clr_n=1 from the first clock after reset deasserts.
  - Config outputs hold their last value. busy=0.
- IDLE -> APPLY when start=1 and stop=0.
  - last_idx is latched; step_idx=0.
- APPLY, entered at cycle t:
  - Config outputs and the dwell register load entry[step_idx] at edge t, so config is valid in the same cycle gen_clr_n falls.
  - gen_clr_n=0 for exactly CLR_CYCLES cycles, then state -> DWELL.
  - busy=1.
- DWELL:
  - gen_clr_n=1. Prescaler counts 0..PRESCALE-1 and emits a tick on wrap. Dwell counter counts ticks.
  - Duration is exactly max(dwell,1)*PRESCALE cycles; dwell=0 is treated as 1.
- End of DWELL:
  - If step_idx != last_idx: step_idx+1 -> APPLY.
  - Else if loop_en=1 (sampled at this cycle): step_idx=0 -> APPLY.
  - Else -> IDLE, seq_done=1 for one cycle, config outputs hold the last entry.
- Total sequence latency without looping: sum over steps of (CLR_CYCLES + max(dwell,1)*PRESCALE) cycles.
- stop=1 in any state: next state IDLE.
  - Counters clear; gen_clr_n=1; config holds; no seq_done.
  - stop wins over a simultaneous start.
- start while busy: ignored; no restart.
- cfg_we:
  - Accepted in any state.
  - The active step uses values latched at its APPLY entry, so a write to the active entry affects only later visits.
  - A write coinciding with the APPLY load of the same address: the old value is applied (read-before-write).
- last_idx >= DEPTH cannot occur (width-limited). last_idx=0 means a single-step program.
- Reset mid-sequence: immediate return to the reset values above, program memory cleared.

Decomposition:
- Package fg_seq_pkg holds:
  - the state enum (IDLE, APPLY, DWELL);
  - entry field offsets and widths (FUNC_LSB=0, FREQ_LSB=3, AMP_LSB=7, PHASE_BIT=9, DWELL_LSB=10);
  - the entry struct typedef.
- Sub-module fg_seq_tick_timer contains the prescaler and dwell counter.
  - Inputs: clear, dwell value. Output: done pulse.
  - Used once; the FSM and register file stay in the top.

Test Plan:
- All tests use PRESCALE=4, CLR_CYCLES=2.
- Reset check: hold reset=0 -> all outputs 0, gen_clr_n=0. After release, gen_clr_n=1 next cycle, busy=0.
- Two steps, no loop:
  - Program entry0={func=3,freq=8,amp=2,ph=1,dwell=3} and entry1={func=1,freq=4,amp=1,ph=0,dwell=1}; last_idx=1, loop_en=0, start pulse.
  - Required: gen_clr_n low 2 cycles, entry0 held 12 DWELL cycles, gen_clr_n low 2, entry1 held 4 cycles.
  - Then seq_done pulses once, busy=0, outputs stay entry1 values.
- Loop: same program with loop_en=1 -> step_idx sequence 0,1,0,1… and no seq_done. Deassert loop_en during step1 -> finishes after step1 with seq_done.
- Dwell=0 and single step: entry0 dwell=0, last_idx=0 -> DWELL lasts exactly 4 cycles, then seq_done.
- Stop/start races:
  - stop and start in the same IDLE cycle -> stays IDLE.
  - stop mid-DWELL -> IDLE next cycle, no seq_done, config held, gen_clr_n=1.
  - start while busy -> no effect on step_idx.
- Write during run: overwrite entry0 while it is active -> active outputs unchanged. With loop_en=1, the second visit applies the new values.

Source files
------------

// File: rtl/fg_seq_pkg.sv
// Shared types and program-entry field layout for the function-generator step sequencer.
package fg_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DWELL = 2'd2
  } state_e;

  localparam int unsigned FUNC_LSB  = 0;
  localparam int unsigned FUNC_W    = 3;
  localparam int unsigned FREQ_LSB  = 3;
  localparam int unsigned FREQ_W    = 4;
  localparam int unsigned AMP_LSB   = 7;
  localparam int unsigned AMP_W     = 2;
  localparam int unsigned PHASE_BIT = 9;
  localparam int unsigned DWELL_LSB = 10;
  localparam int unsigned CFG_W     = 10;

  // Generator configuration carried by one program entry (dwell kept separately).
  typedef struct packed {
    logic              phase;
    logic [AMP_W-1:0]  amp;
    logic [FREQ_W-1:0] freq;
    logic [FUNC_W-1:0] func;
  } fg_cfg_t;

endpackage

// File: rtl/fg_seq_tick_timer.sv
// Dwell timer: prescaler producing ticks, and a tick counter that ends the dwell.
module fg_seq_tick_timer #(
  parameter int unsigned PRESCALE = 1000,
  parameter int unsigned DWELL_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [DWELL_W-1:0] dwell,
  output logic               done_c
);

  localparam int unsigned PRE_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_eff;
  logic               tick;

  // Count prescaler and ticks; a dwell of zero behaves as one tick.
  always_comb begin
    pre_d     = pre_q;
    cnt_d     = cnt_q;
    dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
    tick      = (pre_q == PRE_W'(PRESCALE - 1));
    done_c    = !clear && tick && (cnt_q == (dwell_eff - DWELL_W'(1)));
    if (clear || done_c) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (tick) begin
      pre_d = '0;
      cnt_d = cnt_q + DWELL_W'(1);
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fg_sequencer.sv
// Programmable step sequencer driving the Function_Generator configuration inputs.
module fg_sequencer
  import fg_seq_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned DWELL_W    = 8,
  parameter int unsigned PRESCALE   = 1000,
  parameter int unsigned CLR_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic [CFG_W+DWELL_W-1:0] cfg_wdata,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic [ADDR_W-1:0]        last_idx,
  output logic [FUNC_W-1:0]        func,
  output logic [FREQ_W-1:0]        freq_sel,
  output logic [AMP_W-1:0]         amp_sel,
  output logic                     phase_cntrl,
  output logic                     gen_clr_n,
  output logic                     busy,
  output logic [ADDR_W-1:0]        step_idx,
  output logic                     seq_done
);

  localparam int unsigned CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  state_e             state_q, state_d;
  fg_cfg_t            cfg_mem_q [DEPTH];
  fg_cfg_t            cfg_mem_d [DEPTH];
  logic [DWELL_W-1:0] dwell_mem_q [DEPTH];
  logic [DWELL_W-1:0] dwell_mem_d [DEPTH];
  fg_cfg_t            cfg_q, cfg_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [ADDR_W-1:0]  step_idx_q, step_idx_d;
  logic [ADDR_W-1:0]  last_q, last_d;
  logic [CLR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic               gen_clr_n_q, gen_clr_n_d;
  logic               busy_q, busy_d;
  logic               seq_done_q, seq_done_d;
  fg_cfg_t            wr_cfg;
  logic [DWELL_W-1:0] wr_dwell;
  logic               load;
  logic               timer_clear;
  logic               dwell_done_c;

  // Program memory write port; reads elsewhere see the pre-write contents.
  always_comb begin
    wr_cfg.func  = cfg_wdata[FUNC_LSB +: FUNC_W];
    wr_cfg.freq  = cfg_wdata[FREQ_LSB +: FREQ_W];
    wr_cfg.amp   = cfg_wdata[AMP_LSB +: AMP_W];
    wr_cfg.phase = cfg_wdata[PHASE_BIT];
    wr_dwell     = cfg_wdata[DWELL_LSB +: DWELL_W];
    cfg_mem_d    = cfg_mem_q;
    dwell_mem_d  = dwell_mem_q;
    if (cfg_we) begin
      cfg_mem_d[cfg_addr]   = wr_cfg;
      dwell_mem_d[cfg_addr] = wr_dwell;
    end
  end

  assign timer_clear = stop || (state_q != DWELL);

  fg_seq_tick_timer #(
    .PRESCALE (PRESCALE),
    .DWELL_W  (DWELL_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .dwell  (dwell_q),
    .done_c (dwell_done_c)
  );

  // Next-state and output logic; entering APPLY loads the entry being applied.
  always_comb begin
    state_d    = state_q;
    step_idx_d = step_idx_q;
    last_d     = last_q;
    cfg_d      = cfg_q;
    dwell_d    = dwell_q;
    clr_cnt_d  = '0;
    seq_done_d = 1'b0;
    load       = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d    = APPLY;
            step_idx_d = '0;
            last_d     = last_idx;
            load       = 1'b1;
          end
        end
        APPLY: begin
          if (clr_cnt_q == CLR_W'(CLR_CYCLES - 1)) begin
            state_d = DWELL;
          end else begin
            clr_cnt_d = clr_cnt_q + CLR_W'(1);
          end
        end
        DWELL: begin
          if (dwell_done_c) begin
            if (step_idx_q != last_q) begin
              state_d    = APPLY;
              step_idx_d = step_idx_q + ADDR_W'(1);
              load       = 1'b1;
            end else if (loop_en) begin
              state_d    = APPLY;
              step_idx_d = '0;
              load       = 1'b1;
            end else begin
              state_d    = IDLE;
              seq_done_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (load) begin
      cfg_d   = cfg_mem_q[step_idx_d];
      dwell_d = dwell_mem_q[step_idx_d];
    end
    gen_clr_n_d = (state_d != APPLY);
    busy_d      = (state_d != IDLE);
  end

  // State, program memory and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      for (int i = 0; i < int'(DEPTH); i++) begin
        cfg_mem_q[i]   <= '0;
        dwell_mem_q[i] <= '0;
      end
      cfg_q       <= '0;
      dwell_q     <= '0;
      step_idx_q  <= '0;
      last_q      <= '0;
      clr_cnt_q   <= '0;
      gen_clr_n_q <= 1'b0;
      busy_q      <= 1'b0;
      seq_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_mem_q   <= cfg_mem_d;
      dwell_mem_q <= dwell_mem_d;
      cfg_q       <= cfg_d;
      dwell_q     <= dwell_d;
      step_idx_q  <= step_idx_d;
      last_q      <= last_d;
      clr_cnt_q   <= clr_cnt_d;
      gen_clr_n_q <= gen_clr_n_d;
      busy_q      <= busy_d;
      seq_done_q  <= seq_done_d;
    end
  end

  assign func        = cfg_q.func;
  assign freq_sel    = cfg_q.freq;
  assign amp_sel     = cfg_q.amp;
  assign phase_cntrl = cfg_q.phase;
  assign gen_clr_n   = gen_clr_n_q;
  assign busy        = busy_q;
  assign step_idx    = step_idx_q;
  assign seq_done    = seq_done_q;

endmodule

// File: tb/tb_fg_sequencer.sv
// Directed, table-driven bench for fg_sequencer with PRESCALE=4, CLR_CYCLES=2.
module tb_fg_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [17:0] cfg_wdata = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [2:0]  last_idx = '0;
  logic [2:0]  func;
  logic [3:0]  freq_sel;
  logic [1:0]  amp_sel;
  logic        phase_cntrl;
  logic        gen_clr_n;
  logic        busy;
  logic [2:0]  step_idx;
  logic        seq_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fg_sequencer #(
    .DEPTH      (8),
    .ADDR_W     (3),
    .DWELL_W    (8),
    .PRESCALE   (4),
    .CLR_CYCLES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .start       (start),
    .stop        (stop),
    .loop_en     (loop_en),
    .last_idx    (last_idx),
    .func        (func),
    .freq_sel    (freq_sel),
    .amp_sel     (amp_sel),
    .phase_cntrl (phase_cntrl),
    .gen_clr_n   (gen_clr_n),
    .busy        (busy),
    .step_idx    (step_idx),
    .seq_done    (seq_done)
  );

  // Entries: {dwell[7:0], phase, amp[1:0], freq[3:0], func[2:0]}
  localparam logic [17:0] E0 = {8'd3, 1'b1, 2'd2, 4'd8,  3'd3};
  localparam logic [17:0] E1 = {8'd1, 1'b0, 2'd1, 4'd4,  3'd1};
  localparam logic [17:0] E2 = {8'd0, 1'b0, 2'd3, 4'd2,  3'd5};
  localparam logic [17:0] E3 = {8'd1, 1'b1, 2'd1, 4'd15, 3'd6};

  typedef struct {
    logic        start;
    logic        stop;
    logic        loop_en;
    logic [2:0]  last_idx;
    logic        we;
    logic [2:0]  addr;
    logic [17:0] wdata;
  } in_t;

  typedef struct {
    logic [9:0] cfg;
    logic       clr_n;
    logic       busy;
    logic [2:0] step;
    logic       done;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  vec_t vq[$];

  function automatic logic [9:0] cf(input logic [17:0] x);
    return x[9:0];
  endfunction

  function automatic in_t mi(input logic st, input logic sp, input logic lp, input logic [2:0] li);
    in_t r;
    r.start = st; r.stop = sp; r.loop_en = lp; r.last_idx = li;
    r.we = 1'b0; r.addr = '0; r.wdata = '0;
    return r;
  endfunction

  function automatic in_t mw(input logic [2:0] a, input logic [17:0] d,
                             input logic st, input logic lp, input logic [2:0] li);
    in_t r;
    r = mi(st, 1'b0, lp, li);
    r.we = 1'b1; r.addr = a; r.wdata = d;
    return r;
  endfunction

  function automatic exp_t me(input logic [9:0] c, input logic cl, input logic b,
                              input logic [2:0] s, input logic d);
    exp_t r;
    r.cfg = c; r.clr_n = cl; r.busy = b; r.step = s; r.done = d;
    return r;
  endfunction

  function automatic void add(input int n, input in_t i, input exp_t e);
    vec_t v;
    v.i = i; v.e = e;
    for (int k = 0; k < n; k++) vq.push_back(v);
  endfunction

  task automatic drive(input in_t i);
    start = i.start; stop = i.stop; loop_en = i.loop_en; last_idx = i.last_idx;
    cfg_we = i.we; cfg_addr = i.addr; cfg_wdata = i.wdata;
  endtask

  task automatic check(input string tag, input int idx, input exp_t e);
    logic [9:0] got;
    got = {phase_cntrl, amp_sel, freq_sel, func};
    total++;
    if (got !== e.cfg || gen_clr_n !== e.clr_n || busy !== e.busy ||
        step_idx !== e.step || seq_done !== e.done) begin
      bad++;
      $display("FAIL %s[%0d]: got cfg=%h clr_n=%b busy=%b step=%0d done=%b, want cfg=%h clr_n=%b busy=%b step=%0d done=%b",
               tag, idx, got, gen_clr_n, busy, step_idx, seq_done,
               e.cfg, e.clr_n, e.busy, e.step, e.done);
    end
  endtask

  // Apply queued vectors one per clock, checking registered outputs on the falling edge.
  task automatic run_vecs(input string tag);
    foreach (vq[k]) begin
      drive(vq[k].i);
      @(posedge clk);
      @(negedge clk);
      check(tag, k, vq[k].e);
    end
    vq.delete();
  endtask

  initial begin
    in_t I, L, Z;
    logic [9:0] c0, c1, c2, c3;
    c0 = cf(E0); c1 = cf(E1); c2 = cf(E2); c3 = cf(E3);
    I = mi(1'b0, 1'b0, 1'b0, 3'd1);
    L = mi(1'b0, 1'b0, 1'b1, 3'd1);
    Z = mi(1'b0, 1'b0, 1'b0, 3'd0);

    // Reset held low: everything zero, including gen_clr_n.
    repeat (3) @(negedge clk);
    check("reset_hold", 0, me(10'd0, 1'b0, 1'b0, 3'd0, 1'b0));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_release", 0, me(10'd0, 1'b1, 1'b0, 3'd0, 1'b0));

    // Two steps, no loop.
    add(1, mw(3'd0, E0, 1'b0, 1'b0, 3'd0), me(10'd0, 1'b1, 1'b0, 3'd0, 1'b0));
    add(1, mw(3'd1, E1, 1'b0, 1'b0, 3'd0), me(10'd0, 1'b1, 1'b0, 3'd0, 1'b0));
    add(1, mi(1'b1, 1'b0, 1'b0, 3'd1), me(c0, 1'b0, 1'b1, 3'd0, 1'b0));
    add(1, I,  me(c0, 1'b0, 1'b1, 3'd0, 1'b0));
    add(12, I, me(c0, 1'b1, 1'b1, 3'd0, 1'b0));
    add(2, I,  me(c1, 1'b0, 1'b1, 3'd1, 1'b0));
    add(4, I,  me(c1, 1'b1, 1'b1, 3'd1, 1'b0));
    add(1, I,  me(c1, 1'b1, 1'b0, 3'd1, 1'b1));
    add(1, I,  me(c1, 1'b1, 1'b0, 3'd1, 1'b0));
    run_vecs("two_step");

    // Loop twice through, then drop loop_en during step1.
    add(1, mi(1'b1, 1'b0, 1'b1, 3'd1), me(c0, 1'b0, 1'b1, 3'd0, 1'b0));
    add(1, L,  me(c0, 1'b0, 1'b1, 3'd0, 1'b0));
    add(12, L, me(c0, 1'b1, 1'b1, 3'd0, 1'b0));
    add(2, L,  me(c1, 1'b0, 1'b1, 3'd1, 1'b0));
    add(4, L,  me(c1, 1'b1, 1'b1, 3'd1, 1'b0));
    add(2, L,  me(c0, 1'b0, 1'b1, 3'd0, 1'b0));
    add(12, L, me(c0, 1'b1, 1'b1, 3'd0, 1'b0));
    add(2, L,  me(c1, 1'b0, 1'b1, 3'd1, 1'b0));
    add(4, I,  me(c1, 1'b1, 1'b1, 3'd1, 1'b0));
    add(1, I,  me(c1, 1'b1, 1'b0, 3'd1, 1'b1));
    add(1, I,  me(c1, 1'b1, 1'b0, 3'd1, 1'b0));
    run_vecs("loop");

    // Single step with dwell=0 behaves as one tick.
    add(1, mw(3'd0, E2, 1'b0, 1'b0, 3'd0), me(c1, 1'b1, 1'b0, 3'd1, 1'b0));
    add(1, mi(1'b1, 1'b0, 1'b0, 3'd0), me(c2, 1'b0, 1'b1, 3'd0, 1'b0));
    add(1, Z,  me(c2, 1'b0, 1'b1, 3'd0, 1'b0));
    add(4, Z,  me(c2, 1'b1, 1'b1, 3'd0, 1'b0));
    add(1, Z,  me(c2, 1'b1, 1'b0, 3'd0, 1'b1));
    // Simultaneous stop and start in IDLE stays idle.
    add(1, mi(1'b1, 1'b1, 1'b0, 3'd0), me(c2, 1'b1, 1'b0, 3'd0, 1'b0));
    add(1, Z,  me(c2, 1'b1, 1'b0, 3'd0, 1'b0));
    run_vecs("dwell0_stopstart");

    // Stop mid-DWELL, with start pulses while busy ignored; then full restart timing.
    add(1, mw(3'd0, E0, 1'b0, 1'b0, 3'd0), me(c2, 1'b1, 1'b0, 3'd0, 1'b0));
    add(1, mi(1'b1, 1'b0, 1'b0, 3'd1), me(c0, 1'b0, 1'b1, 3'd0, 1'b0));
    add(1, I,  me(c0, 1'b0, 1'b1, 3'd0, 1'b0));
    add(3, mi(1'b1, 1'b0, 1'b0, 3'd1), me(c0, 1'b1, 1'b1, 3'd0, 1'b0));
    add(2, I,  me(c0, 1'b1, 1'b1, 3'd0, 1'b0));
    add(1, mi(1'b0, 1'b1, 1'b0, 3'd1), me(c0, 1'b1, 1'b0, 3'd0, 1'b0));
    add(1, I,  me(c0, 1'b1, 1'b0, 3'd0, 1'b0));
    add(1, mi(1'b1, 1'b0, 1'b0, 3'd1), me(c0, 1'b0, 1'b1, 3'd0, 1'b0));
    add(1, I,  me(c0, 1'b0, 1'b1, 3'd0, 1'b0));
    add(12, I, me(c0, 1'b1, 1'b1, 3'd0, 1'b0));
    add(1, I,  me(c1, 1'b0, 1'b1, 3'd1, 1'b0));
    add(1, mi(1'b1, 1'b1, 1'b0, 3'd1), me(c1, 1'b1, 1'b0, 3'd1, 1'b0));
    run_vecs("stop_busy");

    // Overwrite entry0 while it is active; the next loop visit uses the new value.
    add(1, mi(1'b1, 1'b0, 1'b1, 3'd1), me(c0, 1'b0, 1'b1, 3'd0, 1'b0));
    add(1, L,  me(c0, 1'b0, 1'b1, 3'd0, 1'b0));
    add(1, mw(3'd0, E3, 1'b0, 1'b1, 3'd1), me(c0, 1'b1, 1'b1, 3'd0, 1'b0));
    add(11, L, me(c0, 1'b1, 1'b1, 3'd0, 1'b0));
    add(2, L,  me(c1, 1'b0, 1'b1, 3'd1, 1'b0));
    add(4, L,  me(c1, 1'b1, 1'b1, 3'd1, 1'b0));
    add(2, L,  me(c3, 1'b0, 1'b1, 3'd0, 1'b0));
    add(4, L,  me(c3, 1'b1, 1'b1, 3'd0, 1'b0));
    add(2, I,  me(c1, 1'b0, 1'b1, 3'd1, 1'b0));
    add(4, I,  me(c1, 1'b1, 1'b1, 3'd1, 1'b0));
    add(1, I,  me(c1, 1'b1, 1'b0, 3'd1, 1'b1));
    run_vecs("write_run");

    // Write coinciding with the APPLY load of the same entry: old value applied.
    add(1, mw(3'd0, E0, 1'b1, 1'b0, 3'd0), me(c3, 1'b0, 1'b1, 3'd0, 1'b0));
    add(1, Z,  me(c3, 1'b0, 1'b1, 3'd0, 1'b0));
    add(4, Z,  me(c3, 1'b1, 1'b1, 3'd0, 1'b0));
    add(1, Z,  me(c3, 1'b1, 1'b0, 3'd0, 1'b1));
    add(1, mi(1'b1, 1'b0, 1'b0, 3'd0), me(c0, 1'b0, 1'b1, 3'd0, 1'b0));
    add(1, Z,  me(c0, 1'b0, 1'b1, 3'd0, 1'b0));
    add(12, Z, me(c0, 1'b1, 1'b1, 3'd0, 1'b0));
    add(1, Z,  me(c0, 1'b1, 1'b0, 3'd0, 1'b1));
    run_vecs("rbw");

    // Reset mid-sequence: immediate return to reset values, program cleared.
    add(1, mi(1'b1, 1'b0, 1'b0, 3'd1), me(c0, 1'b0, 1'b1, 3'd0, 1'b0));
    add(1, I,  me(c0, 1'b0, 1'b1, 3'd0, 1'b0));
    add(3, I,  me(c0, 1'b1, 1'b1, 3'd0, 1'b0));
    run_vecs("pre_reset");
    #2 reset = 1'b0;
    #1 check("reset_async", 0, me(10'd0, 1'b0, 1'b0, 3'd0, 1'b0));
    @(negedge clk);
    check("reset_async", 1, me(10'd0, 1'b0, 1'b0, 3'd0, 1'b0));
    reset = 1'b1;
    add(1, mi(1'b1, 1'b0, 1'b0, 3'd0), me(10'd0, 1'b0, 1'b1, 3'd0, 1'b0));
    add(1, Z,  me(10'd0, 1'b0, 1'b1, 3'd0, 1'b0));
    add(4, Z,  me(10'd0, 1'b1, 1'b1, 3'd0, 1'b0));
    add(1, Z,  me(10'd0, 1'b1, 1'b0, 3'd0, 1'b1));
    run_vecs("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
